// File: rtl/intc_pkg.sv
// intc_pkg: FSM encoding, register map and vector defaults shared by the interrupt controller
package intc_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;
    localparam logic [1:0] INTC_ENABLE  = 2'd0;
    localparam logic [1:0] INTC_PENDING = 2'd1;
    localparam logic [1:0] INTC_STATUS  = 2'd2;
    localparam logic [1:0] INTC_GIE     = 2'd3;
    localparam int unsigned VEC_BASE_DEF   = 32'h0010;
    localparam int unsigned VEC_STRIDE_DEF = 2;
endpackage

// File: rtl/intc_prio.sv
// intc_prio: lowest-index-wins 8-to-3 priority encoder
//   req_i   : active request bits
//   idx_o   : index of the lowest set bit (0 when none)
//   valid_o : any bit set
module intc_prio (
    input  logic [7:0] req_i,
    output logic [2:0] idx_o,
    output logic       valid_o
);
    always_comb begin
        idx_o = '0;
        for (int i = 7; i >= 0; i--)
            if (req_i[i]) idx_o = 3'(i);
    end
    assign valid_o = |req_i;
endmodule

// File: rtl/intc.sv
// intc: 8-source edge-triggered interrupt controller with one outstanding request
//   clk, rst_n        : clock, async active-low reset
//   irq_src           : raw asynchronous interrupt lines (rising edge)
//   irq_req/vec/pc    : request, source index and handler address to fetch
//   irq_ack, eoi      : request taken by fetch / handler returned
//   cfg_we/addr/wd/rd : register bus (ENABLE, PENDING, STATUS, GIE)
module intc
    import intc_pkg::*;
#(
    parameter int          CPU_WIDTH  = 16,
    parameter int unsigned VEC_BASE   = VEC_BASE_DEF,
    parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           irq_src,
    output logic                 irq_req,
    output logic [2:0]           irq_vec,
    output logic [CPU_WIDTH-1:0] irq_pc,
    input  logic                 irq_ack,
    input  logic                 eoi,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_addr,
    input  logic [CPU_WIDTH-1:0] cfg_wd,
    output logic [CPU_WIDTH-1:0] cfg_rd
);
    logic [7:0] s1_q, s2_q, prev_q, en_q, en_d, pend_q, pend_d;
    logic [7:0] rise, clr, act;
    logic [1:0] arm_q;
    logic       gie_q, gie_d, act_v;
    logic [2:0] vec_q, vec_d, act_idx;
    state_e     state_q, state_d;
    logic       unused_wd;

    intc_prio u_prio (.req_i(act), .idx_o(act_idx), .valid_o(act_v));

    always_comb begin
        // edges are masked until prev has captured a real sample, so a line
        // already high at reset release is not seen as rising
        rise   = (arm_q == 2'd3) ? (s2_q & ~prev_q) : '0;
        clr    = ((state_q == ST_REQ && irq_ack) ? (8'd1 << vec_q) : 8'd0)
               | ((cfg_we && cfg_addr == INTC_PENDING) ? cfg_wd[7:0] : 8'd0);
        pend_d = (pend_q & ~clr) | rise;
        en_d   = (cfg_we && cfg_addr == INTC_ENABLE) ? cfg_wd[7:0] : en_q;
        gie_d  = (cfg_we && cfg_addr == INTC_GIE) ? cfg_wd[0] : gie_q;
        act    = pend_q & en_q;
        state_d = state_q;
        vec_d   = vec_q;
        case (state_q)
            ST_IDLE: if (gie_q && act_v) begin
                state_d = ST_REQ;
                vec_d   = act_idx;
            end
            ST_REQ: state_d = irq_ack ? ST_SERVICE : (!gie_d ? ST_IDLE : ST_REQ);
            ST_SERVICE: state_d = eoi ? ST_IDLE : ST_SERVICE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
            arm_q   <= '0;
            en_q    <= '0;
            pend_q  <= '0;
            gie_q   <= 1'b0;
            vec_q   <= '0;
            state_q <= ST_IDLE;
        end else begin
            s1_q    <= irq_src;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            arm_q   <= (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
            en_q    <= en_d;
            pend_q  <= pend_d;
            gie_q   <= gie_d;
            vec_q   <= vec_d;
            state_q <= state_d;
        end
    end

    assign irq_req = (state_q == ST_REQ);
    assign irq_vec = vec_q;
    assign irq_pc  = CPU_WIDTH'(VEC_BASE + 32'(vec_q) * VEC_STRIDE);
    assign cfg_rd  = (cfg_addr == INTC_ENABLE)  ? CPU_WIDTH'(en_q)
                   : (cfg_addr == INTC_PENDING) ? CPU_WIDTH'(pend_q)
                   : (cfg_addr == INTC_STATUS)  ? CPU_WIDTH'({state_q, vec_q})
                   : CPU_WIDTH'(gie_q);
    assign unused_wd = ^cfg_wd[CPU_WIDTH-1:8];
endmodule

// File: doc/intc.md
INTC -- requirements
Module: intc

Interface
REQ-001 Parameter CPU_WIDTH, default 16, data width of the configuration bus.
REQ-002 Parameter VEC_BASE, default 16'h0010, address of vector 0.
REQ-003 Parameter VEC_STRIDE, default 2, address step between vectors.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 irq_src  input  8  raw asynchronous interrupt lines, rising-edge triggered.
REQ-007 irq_req  output  1  interrupt request to the fetch stage.
REQ-008 irq_vec  output  3  index of the requested source, valid while irq_req=1.
REQ-009 irq_pc  output  CPU_WIDTH  handler address = VEC_BASE + irq_vec*VEC_STRIDE.
REQ-010 irq_ack  input  1  fetch stage has taken the request (one-cycle pulse).
REQ-011 eoi  input  1  end-of-interrupt pulse from the handler's return.
REQ-012 cfg_we  input  1  configuration write strobe.
REQ-013 cfg_addr  input  2  register select.
REQ-014 cfg_wd  input  CPU_WIDTH  write data.
REQ-015 cfg_rd  output  CPU_WIDTH  read data, combinational from cfg_addr.

Function
REQ-016 Each irq_src bit SHALL pass a 2-flop synchroniser, then a rising-edge detector (sync2 & ~prev).
- A rising edge sets PENDING[i] on the 3rd clk edge after the line goes high.
REQ-017 Register map:
- 0 ENABLE[7:0] R/W.
- 1 PENDING[7:0] R; a write of 1 clears the bit.
- 2 STATUS {state[1:0], vec[2:0]} R.
- 3 GIE bit0 R/W.
- Unused bits read 0.
REQ-018 FSM states IDLE, REQ, SERVICE; no nesting.
REQ-019 IDLE: if GIE=1 and (PENDING & ENABLE) != 0, latch the lowest-index active bit into vec; go to REQ.
REQ-020 REQ: irq_req=1; vec and irq_pc held stable.
- On irq_ack: clear PENDING[vec] and go to SERVICE.
- If GIE is written 0 before ack: return to IDLE, irq_req drops next cycle, PENDING is kept.
REQ-021 SERVICE: irq_req=0; on eoi, go to IDLE.
- The next request may issue the cycle after IDLE is re-entered.
REQ-022 Latency: irq_req SHALL rise on the 4th clk edge after an irq_src rising edge when IDLE, GIE=1 and the source is enabled.
REQ-023 PENDING SHALL latch regardless of ENABLE; enabling later raises a request.
REQ-024 A new edge on bit i in the same cycle as a clear of bit i (by ack or cfg write) SHALL leave PENDING[i]=1 (set wins).
REQ-025 irq_ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-026 A second edge on a source already pending SHALL be merged; no count is kept.
REQ-027 irq_pc SHALL be computed modulo 2^CPU_WIDTH.

Reset
REQ-028 On rst_n=0, asynchronously:
- state=IDLE, vec=0, ENABLE=0, PENDING=0, GIE=0, synchroniser and prev flops=0.
- irq_req=0, irq_vec=0, irq_pc=VEC_BASE.
REQ-029 Reset during REQ or SERVICE SHALL abandon the interrupt with no pending state retained.
REQ-030 An irq_src line already high at reset release SHALL NOT produce an edge.

Structure
REQ-031 A shared package SHALL hold:
- FSM state encoding.
- Register address constants INTC_ENABLE=0, INTC_PENDING=1, INTC_STATUS=2, INTC_GIE=3.
- Defaults of VEC_BASE and VEC_STRIDE.
REQ-032 One sub-module, intc_prio: combinational 8-to-3 lowest-index priority encoder with any-valid output.
REQ-033 intc SHALL replace the raw irq bus at the CPU top; irq_ack comes from the fetch stage and eoi from decode of the return instruction.

Verification
REQ-034 ENABLE=0x01, GIE=1, pulse irq_src[0] -> irq_req high after 4th edge, irq_vec=0, irq_pc=0x0010; ack -> SERVICE; eoi -> IDLE.
REQ-035 ENABLE=0xFF, edges on bits 5 and 2 in the same cycle -> vec=2 first (irq_pc=0x0014); after eoi, vec=5 (irq_pc=0x001A).
REQ-036 ENABLE=0x00, edge on bit 3 -> PENDING=0x08, irq_req stays 0; write ENABLE=0x08 -> irq_req rises; write PENDING=0x08 before it rises -> no request.
REQ-037 In REQ with vec=1, write GIE=0 -> irq_req drops, PENDING[1] stays 1; GIE=1 -> request reissues with vec=1.
REQ-038 New edge on bit 4 in the same cycle as irq_ack for vec=4 -> PENDING[4]=1 after ack; second request after eoi.
REQ-039 Assert rst_n=0 in SERVICE with PENDING=0x81 -> all outputs and registers are at reset values immediately; irq_src held high through reset release -> no request.
